// File: rtl/cond_unit_pkg.sv
// Shared definitions for the processor status / branch-condition unit.
// Condition-code encoding, PSR flag bit positions and the masked PSR merge helper.
package cond_unit_pkg;

  localparam int PSR_W  = 5;
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_HI = 4'd4,
    COND_LS = 4'd5,
    COND_GT = 4'd6,
    COND_LE = 4'd7,
    COND_FS = 4'd8,
    COND_FC = 4'd9,
    COND_LO = 4'd10,
    COND_HS = 4'd11,
    COND_LT = 4'd12,
    COND_GE = 4'd13,
    COND_UC = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EVAL = 1'b1
  } qstate_e;

  function automatic logic [PSR_W-1:0] psr_merge(input logic [PSR_W-1:0] old_psr,
                                                 input logic [PSR_W-1:0] new_bits,
                                                 input logic [PSR_W-1:0] mask);
    return (old_psr & ~mask) | (new_bits & mask);
  endfunction

endpackage

// File: rtl/cond_unit_eval.sv
// Combinational branch-condition evaluator: (flags, cond) -> taken.
// Kept standalone so the decode stage can reuse it.
module cond_eval
  import cond_unit_pkg::*;
(
  input  logic [PSR_W-1:0] flags,
  input  logic [3:0]       cond,
  output logic             taken
);

  logic f_c, f_l, f_f, f_z, f_n;

  assign f_c = flags[FLAG_C];
  assign f_l = flags[FLAG_L];
  assign f_f = flags[FLAG_F];
  assign f_z = flags[FLAG_Z];
  assign f_n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = f_z;
      COND_NE: taken = ~f_z;
      COND_CS: taken = f_c;
      COND_CC: taken = ~f_c;
      COND_HI: taken = f_l;
      COND_LS: taken = ~f_l;
      COND_GT: taken = f_n;
      COND_LE: taken = ~f_n;
      COND_FS: taken = f_f;
      COND_FC: taken = ~f_f;
      COND_LO: taken = ~f_l & ~f_z;
      COND_HS: taken = f_l | f_z;
      COND_LT: taken = ~f_n & ~f_z;
      COND_GE: taken = f_n | f_z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// PSR holder, save stack and registered branch-condition query unit.
// Define COND_UNIT_FWD_EN to let a query see the same-edge PSR update.
//
//   state   | meaning
//   ST_IDLE | ready for a query; accept on req_valid
//   ST_EVAL | result presented on resp_valid/resp_taken for one cycle
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] flag_in,
  input  logic             flag_we,
  input  logic [4:0]       flag_mask,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  output logic             resp_valid,
  output logic             resp_taken,
  input  logic             push,
  input  logic             pop,
  output logic [4:0]       psr,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  qstate_e          state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic [PSR_W-1:0] psr_q, psr_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [PSR_W-1:0] stack_q [DEPTH];
  logic [PSR_W-1:0] stack_d [DEPTH];
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;

  logic             full_now, empty_now;
  logic             do_push, do_pop;
  logic [SP_W-1:0]  sp_dec;
  logic [PSR_W-1:0] eval_flags;
  logic             eval_taken;
  logic             unused_flag_bits;

  assign unused_flag_bits = ^flag_in[WIDTH-1:PSR_W];

  assign full_now  = (sp_q == SP_W'(DEPTH));
  assign empty_now = (sp_q == '0);
  assign do_push   = push & ~pop;
  assign do_pop    = pop & ~push;
  assign sp_dec    = sp_q - SP_W'(1);

  // PSR and stack next state; push+pop together leaves both untouched
  always_comb begin
    psr_d   = psr_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    err_d   = err_q;
    if (do_pop) begin
      if (empty_now) begin
        err_d = 1'b1;
      end else begin
        psr_d = stack_q[sp_dec[IDX_W-1:0]];
        sp_d  = sp_dec;
      end
    end else if (!(push && pop)) begin
      if (do_push) begin
        if (full_now) begin
          err_d = 1'b1;
        end else begin
          stack_d[sp_q[IDX_W-1:0]] = psr_q;
          sp_d = sp_q + SP_W'(1);
        end
      end
      if (flag_we) begin
        psr_d = psr_merge(psr_q, flag_in[PSR_W-1:0], flag_mask);
      end
    end
    full_d  = (sp_d == SP_W'(DEPTH));
    empty_d = (sp_d == '0);
  end

`ifdef COND_UNIT_FWD_EN
  assign eval_flags = psr_d;
`else
  assign eval_flags = psr_q;
`endif

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (req_cond),
    .taken (eval_taken)
  );

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_EVAL;
          taken_d = eval_taken;
        end
      end
      ST_EVAL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_EVAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      psr_q   <= '0;
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      psr_q   <= psr_d;
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_taken = taken_q;
  assign psr        = psr_q;
  assign stk_full   = full_q;
  assign stk_empty  = empty_q;
  assign stk_err    = err_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed scenarios plus random traffic,
// checked against a behavioural model of PSR, stack and condition rules.
module tb_cond_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] flag_in = '0;
  logic             flag_we = 1'b0;
  logic [4:0]       flag_mask = '0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_cond = '0;
  logic             resp_valid;
  logic             resp_taken;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [4:0]       psr;
  logic             stk_full, stk_empty, stk_err;

  cond_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flag_in    (flag_in),
    .flag_we    (flag_we),
    .flag_mask  (flag_mask),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cond   (req_cond),
    .resp_valid (resp_valid),
    .resp_taken (resp_taken),
    .push       (push),
    .pop        (pop),
    .psr        (psr),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_err    (stk_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit [4:0] m_psr;
  bit [4:0] m_stk[$];
  bit       m_err;
  bit       m_ready;
  bit       exp_q[$];

`ifdef COND_UNIT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Conditions 0..9 pair a single flag with its inverse; 10..13 pair (X|Z) with its inverse.
  function automatic bit model_cond(input bit [4:0] f, input int c);
    bit base;
    if (c < 10) begin
      case (c / 2)
        0: base = f[3];
        1: base = f[0];
        2: base = f[1];
        3: base = f[4];
        default: base = f[2];
      endcase
      return (c % 2 == 0) ? base : !base;
    end
    if (c < 14) begin
      base = (c < 12) ? (f[1] | f[3]) : (f[4] | f[3]);
      return (c % 2 == 1) ? base : !base;
    end
    return c == 14;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
        else check("resp_taken", resp_taken, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        check("resp_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_clear();
    m_psr   = '0;
    m_stk.delete();
    m_err   = 1'b0;
    m_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_psr", psr, 0);
    check("rst_empty", stk_empty, 1);
    check("rst_full", stk_full, 0);
    check("rst_err", stk_err, 0);
    check("rst_ready", req_ready, 1);
    check("rst_valid", resp_valid, 0);
    check("rst_taken", resp_taken, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input bit fwe, input bit [15:0] fin, input bit [4:0] fm,
                      input bit rv, input bit [3:0] rc, input bit ps, input bit pp);
    bit [4:0] pre;
    bit       acc;
    flag_we = fwe; flag_in = fin; flag_mask = fm;
    req_valid = rv; req_cond = rc; push = ps; pop = pp;
    @(posedge clk);
    pre = m_psr;
    acc = m_ready && rv;
    if (ps && pp) begin
    end else if (pp) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_psr = m_stk.pop_back();
    end else begin
      if (ps) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(pre);
      end
      if (fwe) m_psr = (pre & ~fm) | (fin[4:0] & fm);
    end
    if (acc) exp_q.push_back(model_cond(FWD ? m_psr : pre, int'(rc)));
    m_ready = !acc;
    #1;
    check("psr", psr, m_psr);
    check("stk_full", stk_full, m_stk.size() == DEPTH);
    check("stk_empty", stk_empty, m_stk.size() == 0);
    check("stk_err", stk_err, m_err);
    check("req_ready", req_ready, m_ready);
    @(negedge clk);
    flag_we = 0; req_valid = 0; push = 0; pop = 0;
  endtask

  task automatic set_flags(input bit [4:0] v);
    step(1, {11'd0, v}, 5'h1F, 0, 0, 0, 0);
  endtask

  task automatic query(input bit [3:0] c);
    step(0, 0, 0, 1, c, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit [4:0] vals [4];
    vals[0] = 5'h01; vals[1] = 5'h02; vals[2] = 5'h04; vals[3] = 5'h08;
    model_clear();
    @(negedge clk);
    do_reset();

    set_flags(5'h08);
    query(4'd0);
    query(4'd1);
    set_flags(5'b00010);
    query(4'd4); query(4'd10); query(4'd11);
    set_flags(5'b01000);
    query(4'd10); query(4'd11);

    set_flags(5'h1F);
    step(1, 16'h0000, 5'b00001, 0, 0, 0, 0);
    check("mask_psr", psr, 5'h1E);

    for (int i = 0; i < 4; i++) begin
      set_flags(vals[i]);
      step(0, 0, 0, 0, 0, 1, 0);
    end
    check("stack_full", stk_full, 1);
    set_flags(5'h15);
    step(0, 0, 0, 0, 0, 1, 0);
    check("overflow_err", stk_err, 1);
    for (int i = 3; i >= 0; i--) begin
      step(0, 0, 0, 0, 0, 0, 1);
      check("lifo_psr", psr, vals[i]);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    check("underflow_psr", psr, 5'h01);
    check("underflow_empty", stk_empty, 1);

    do_reset();
    set_flags(5'h03);
    step(1, 16'h0010, 5'h1F, 0, 0, 1, 0);
    check("push_we_psr", psr, 5'h10);
    step(0, 0, 0, 0, 0, 0, 1);
    check("push_we_pop", psr, 5'h03);

    set_flags(5'h00);
    step(1, 16'h0008, 5'h1F, 1, 4'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    step(0, 0, 0, 1, 4'd14, 0, 0);
    check("b2b_ready0", req_ready, 0);
    step(0, 0, 0, 1, 4'd15, 0, 0);
    check("b2b_ready1", req_ready, 1);
    step(0, 0, 0, 1, 4'd14, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset while a response is pending must suppress it.
    req_valid = 1; req_cond = 4'd14;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    check("midq_valid", resp_valid, 0);
    @(negedge clk);
    check("midq_valid_neg", resp_valid, 0);
    req_valid = 0;
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 3, 16'($urandom), 5'($urandom),
           $urandom_range(0, 1) == 1, 4'($urandom),
           $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("resp_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Processor status and branch-condition unit. It consumes the flag word produced by the ALU, holds the 5-bit processor status register (PSR), and answers branch/jump condition queries with a registered taken/not-taken result. It sits between the ALU flag output and the fetch/branch logic. It also keeps a small hardware stack of saved PSR values for interrupt entry and return.

## Interface
- WIDTH, 16: width of the ALU flag word; only bits [4:0] are used.
- DEPTH, 4: PSR save-stack entries (power of 2, ≥2).

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flag_in  in  WIDTH  ALU flag word: bit0 C, bit1 L, bit2 F (overflow), bit3 Z (equal), bit4 N
- flag_we  in  1  load PSR from flag_in[4:0] at this edge
- flag_mask  in  5  per-bit write enable for flag_we (1 = update the bit)
- req_valid  in  1  condition query present
- req_ready  out  1  unit can accept a query
- req_cond  in  4  condition code
- resp_valid  out  1  result valid; one-cycle pulse
- resp_taken  out  1  condition result
- push  in  1  save PSR to stack (interrupt entry)
- pop  in  1  restore PSR from stack (interrupt return)
- psr  out  5  current PSR
- stk_full / stk_empty  out  1  stack status
- stk_err  out  1  sticky overflow/underflow flag; cleared only by reset

## Operation
- Condition codes (f = evaluated flags):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F.
  - 10 LO !L&!Z; 11 HS L|Z; 12 LT !N&!Z; 13 GE N|Z; 14 UC 1; 15 NV 0.
- Query FSM has two states:
  - IDLE: req_ready=1. Accept on req_valid → EVAL, capturing req_cond and the evaluated flags.
  - EVAL: resp_valid=1, resp_taken=registered result, req_ready=0 → IDLE.
  - A new query can be accepted at most every 2 cycles.
- PSR write: psr[i] ← flag_in[i] where flag_we & flag_mask[i]; other bits hold.
- Push: stack[sp] ← psr (the pre-update value), sp+1.
- Pop: psr ← stack[sp-1], sp-1.
- Priority per edge:
  - pop overrides flag_we.
  - push and flag_we together: the old PSR is saved, then the PSR updates.
  - push and pop together: no-op on both the stack and the PSR; it is not an error.
- Push while full: ignored, stk_err←1. Pop while empty: ignored, PSR unchanged, stk_err←1.
- Pointer sp is $clog2(DEPTH)+1 bits; full when sp==DEPTH, empty when sp==0. The pointer never wraps.

## Timing
- Reset values: psr=0, sp=0, stk_empty=1, stk_full=0, stk_err=0, FSM=IDLE, req_ready=1, resp_valid=0, resp_taken=0.
- Query latency: response in the cycle after acceptance.
- Flags used for a query are the PSR as of the acceptance edge, i.e. before any same-edge update, unless forwarding is enabled (see Configuration).
- PSR, stack, and status outputs update at the edge. All outputs are registered.
- Reset mid-query drops the query; no resp_valid is issued.

## Configuration
- COND_UNIT_FWD_EN defined: a query accepted in the same cycle as flag_we evaluates against the merged value (masked flag_in bits replace PSR bits). A same-cycle pop forwards the popped value instead.
- Not defined: queries always see the registered PSR. Software/pipeline must insert one cycle between a flag-setting op and a dependent branch.

## Structure
- Shared package: the condition-code enum (EQ..NV), the flag bit index constants (C=0, L=1, F=2, Z=3, N=4), and the PSR width constant (5).
- One sub-module: cond_eval, purely combinational: (flags[4:0], cond[3:0]) → taken. It is reusable by the decode stage.
- Stack: a register array in the top module; no memory macro.

## Test plan
- Reset, then flag_we=1, mask=5'h1F, flag_in=16'h0008; query EQ → resp_taken=1 one cycle after acceptance; NE → 0.
- psr=5'b00010 (L); query HI → 1, LO → 0, HS → 1; psr=5'b01000 (Z): LO → 0, HS → 1.
- Mask test: psr=5'h1F, flag_we with flag_in=0, mask=5'b00001 → psr=5'h1E.
- Stack: 4 pushes with distinct PSRs → stk_full=1; 5th push → stk_err=1, contents intact; 4 pops restore in LIFO order; extra pop → psr unchanged, stk_empty=1.
- Push+flag_we in the same cycle with psr=5'h03, flag_in=5'h10 → psr=5'h10; pop → psr=5'h03.
- Same-cycle flag_we(Z=1) + EQ query with psr Z=0 → taken=1 with COND_UNIT_FWD_EN, 0 without. Back-to-back req_valid → second query is accepted 2 cycles after the first.
